adc_cal_sequencer: RTL and testbench

Sequences the 4-channel ADC capture datapath (vout, iout, vcap, icap) between idle, settling, zero-offset calibration and run phases.
- Gates sampling through adc_en.
- Averages 2^CAL_LOG2 samples per channel to learn offsets, then streams offset-corrected samples to the fire controller.
- Sits between the ADC receiver and the launch state machine / current model.

---
 rtl/adc_cal_sequencer_pkg.sv | 19 +
 rtl/adc_cal_sequencer_if.sv | 30 +++
 rtl/adc_cal_sequencer_channel.sv | 56 +++++
 rtl/adc_cal_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_adc_cal_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_cal_sequencer_pkg.sv
// Shared types and constants for the ADC offset calibration sequencer.
// Exports state_t, ADC_W, NUM_CH and default limits.
package adc_cal_pkg;

  localparam int ADC_W  = 12;
  localparam int NUM_CH = 4;

  localparam logic [ADC_W-1:0] DEF_MAX_OFFSET = 12'h040;
  localparam int DEF_STROBE_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ACCUM,
    CHECK,
    RUN
  } state_t;

endpackage

// File: rtl/adc_cal_sequencer_if.sv
// ADC sample bus: raw holds + ad_strobe in, adc_en + corrected samples out.
// master = receiver/consumer side, slave = sequencer side.
interface adc_cal_sequencer_if;
  import adc_cal_pkg::*;

  logic             adc_en;
  logic [ADC_W-1:0] ad_a0;
  logic [ADC_W-1:0] ad_a1;
  logic [ADC_W-1:0] ad_b0;
  logic [ADC_W-1:0] ad_b1;
  logic             ad_strobe;
  logic [ADC_W-1:0] corr_a0;
  logic [ADC_W-1:0] corr_a1;
  logic [ADC_W-1:0] corr_b0;
  logic [ADC_W-1:0] corr_b1;
  logic             corr_strobe;

  modport master (
    output ad_a0, ad_a1, ad_b0, ad_b1, ad_strobe,
    input  adc_en,
    input  corr_a0, corr_a1, corr_b0, corr_b1, corr_strobe
  );

  modport slave (
    input  ad_a0, ad_a1, ad_b0, ad_b1, ad_strobe,
    output adc_en,
    output corr_a0, corr_a1, corr_b0, corr_b1, corr_strobe
  );

endinterface

// File: rtl/adc_cal_sequencer_channel.sv
// One ADC channel: accumulator, offset register, range check, saturating
// correction. Ports: acc_clr/acc_en/off_ld/corr_en controls, sample in,
// in_range/offset/corr out. ADC_CAL_ROUND_EN selects round-half-up average.
module adc_cal_channel
  import adc_cal_pkg::*;
#(
  parameter int               CAL_LOG2   = 4,
  parameter logic [ADC_W-1:0] MAX_OFFSET = DEF_MAX_OFFSET
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_clr,
  input  logic             acc_en,
  input  logic             off_ld,
  input  logic             corr_en,
  input  logic [ADC_W-1:0] sample,
  output logic             in_range,
  output logic [ADC_W-1:0] offset,
  output logic [ADC_W-1:0] corr
);

  localparam int ACC_W = ADC_W + CAL_LOG2;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_r;
  logic [ADC_W-1:0] avg;

`ifdef ADC_CAL_ROUND_EN
  // Max acc is 2^L*(2^12-1); adding 2^(L-1) still fits ACC_W.
  localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (CAL_LOG2 - 1);
  assign sum_r = acc + HALF;
`else
  assign sum_r = acc;
`endif

  assign avg      = sum_r[ACC_W-1:CAL_LOG2];
  assign in_range = (avg <= MAX_OFFSET);

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc    <= '0;
      offset <= '0;
      corr   <= '0;
    end else begin
      if (acc_clr)
        acc <= '0;
      else if (acc_en)
        acc <= acc + ACC_W'(sample);
      if (off_ld)
        offset <= avg;
      if (corr_en)
        corr <= (sample >= offset) ? sample - offset : '0;
    end
  end

endmodule

// File: rtl/adc_cal_sequencer.sv
// Calibration sequencer: settle, average 2^CAL_LOG2 samples, range check,
// then stream offset-corrected samples. Ports: clk, reset (sync, low),
// cal_req, bus (slave), cal_busy/done/err, off_*. Option: ADC_CAL_ROUND_EN.
module adc_cal_sequencer
  import adc_cal_pkg::*;
#(
  parameter int               SETTLE_SAMPLES = 2,
  parameter int               CAL_LOG2       = 4,
  parameter logic [ADC_W-1:0] MAX_OFFSET     = DEF_MAX_OFFSET,
  parameter int               STROBE_TIMEOUT = DEF_STROBE_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cal_req,
  adc_cal_sequencer_if.slave  bus,
  output logic                cal_busy,
  output logic                cal_done,
  output logic                cal_err,
  output logic [ADC_W-1:0]    off_a0,
  output logic [ADC_W-1:0]    off_a1,
  output logic [ADC_W-1:0]    off_b0,
  output logic [ADC_W-1:0]    off_b1
);

  localparam int SW    = $clog2(SETTLE_SAMPLES + 1);
  localparam int CNT_W = (CAL_LOG2 + 1 > SW) ? CAL_LOG2 + 1 : SW;
  localparam int TMO_W = $clog2(STROBE_TIMEOUT + 1);

  state_t state, nxt;

  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;

  logic acc_clr, acc_en, off_ld, corr_en;
  logic cnt_clr, cnt_inc;
  logic err_set, err_clr, done_set;
  logic tmo_hit, last_set, last_acc, all_ok;
  logic strobe;

  logic [ADC_W-1:0]  smp  [NUM_CH];
  logic [ADC_W-1:0]  off  [NUM_CH];
  logic [ADC_W-1:0]  corr [NUM_CH];
  logic [NUM_CH-1:0] in_rng;

  assign strobe   = bus.ad_strobe;
  assign last_set = (cnt == CNT_W'(SETTLE_SAMPLES - 1));
  assign last_acc = (cnt == CNT_W'((1 << CAL_LOG2) - 1));
  assign tmo_hit  = !strobe &&
                    (tmo == TMO_W'(STROBE_TIMEOUT - 1));
  assign all_ok   = &in_rng;

  always_comb begin
    nxt      = state;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    off_ld   = 1'b0;
    corr_en  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    done_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (cal_req) begin
          nxt     = SETTLE;
          err_clr = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      SETTLE: begin
        if (strobe) begin
          if (last_set) begin
            nxt     = ACCUM;
            acc_clr = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end else if (tmo_hit) begin
          nxt     = IDLE;
          err_set = 1'b1;
        end
      end
      ACCUM: begin
        if (strobe) begin
          acc_en = 1'b1;
          if (last_acc) begin
            nxt     = CHECK;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end else if (tmo_hit) begin
          nxt     = IDLE;
          err_set = 1'b1;
        end
      end
      CHECK: begin
        if (all_ok) begin
          nxt      = RUN;
          off_ld   = 1'b1;
          done_set = 1'b1;
        end else begin
          nxt     = IDLE;
          err_set = 1'b1;
        end
      end
      RUN: begin
        corr_en = strobe;
        if (cal_req) begin
          nxt     = SETTLE;
          err_clr = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt             <= '0;
      tmo             <= '0;
      cal_err         <= 1'b0;
      cal_done        <= 1'b0;
      bus.corr_strobe <= 1'b0;
    end else begin
      if (cnt_clr)
        cnt <= '0;
      else if (cnt_inc)
        cnt <= cnt + 1'b1;
      // Cycles since last strobe; only runs while waiting on samples.
      if ((state == SETTLE || state == ACCUM) && !strobe)
        tmo <= tmo + 1'b1;
      else
        tmo <= '0;
      if (err_set)
        cal_err <= 1'b1;
      else if (err_clr)
        cal_err <= 1'b0;
      cal_done        <= done_set;
      bus.corr_strobe <= corr_en;
    end
  end

  assign bus.adc_en = (state != IDLE);
  assign cal_busy   = (state == SETTLE) || (state == ACCUM) ||
                      (state == CHECK);

  assign smp[0] = bus.ad_a0;
  assign smp[1] = bus.ad_a1;
  assign smp[2] = bus.ad_b0;
  assign smp[3] = bus.ad_b1;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    adc_cal_channel #(
      .CAL_LOG2   (CAL_LOG2),
      .MAX_OFFSET (MAX_OFFSET)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .acc_clr  (acc_clr),
      .acc_en   (acc_en),
      .off_ld   (off_ld),
      .corr_en  (corr_en),
      .sample   (smp[i]),
      .in_range (in_rng[i]),
      .offset   (off[i]),
      .corr     (corr[i])
    );
  end

  assign off_a0 = off[0];
  assign off_a1 = off[1];
  assign off_b0 = off[2];
  assign off_b1 = off[3];

  assign bus.corr_a0 = corr[0];
  assign bus.corr_a1 = corr[1];
  assign bus.corr_b0 = corr[2];
  assign bus.corr_b1 = corr[3];

endmodule

// File: tb/tb_adc_cal_sequencer.sv
// Self-checking bench for adc_cal_sequencer with a behavioural model of
// averaging, range check and saturating correction.
module tb_adc_cal_sequencer;
  import adc_cal_pkg::*;

  localparam int NSTR = 18;
  localparam int NSET = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cal_req = 1'b0;
  logic cal_busy, cal_done, cal_err;
  logic [11:0] off_a0, off_a1, off_b0, off_b1;

  int total = 0;
  int bad = 0;

  logic [11:0] vals [NSTR][4];
  logic [11:0] m_off [4];
  logic [11:0] v [4];

  always #5 clk = ~clk;

  adc_cal_sequencer_if bus ();

  adc_cal_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .cal_req  (cal_req),
    .bus      (bus),
    .cal_busy (cal_busy),
    .cal_done (cal_done),
    .cal_err  (cal_err),
    .off_a0   (off_a0),
    .off_a1   (off_a1),
    .off_b0   (off_b0),
    .off_b1   (off_b1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] off_of(input int c);
    case (c)
      0: return off_a0;
      1: return off_a1;
      2: return off_b0;
      default: return off_b1;
    endcase
  endfunction

  function automatic logic [11:0] corr_of(input int c);
    case (c)
      0: return bus.corr_a0;
      1: return bus.corr_a1;
      2: return bus.corr_b0;
      default: return bus.corr_b1;
    endcase
  endfunction

  function automatic logic [11:0] sat(input logic [11:0] x,
                                     input logic [11:0] o);
    return (x >= o) ? x - o : 12'h000;
  endfunction

  // Mean of the 16 post-settle samples of a channel.
  function automatic logic [11:0] avg_of(input int c);
    int s = 0;
    for (int i = NSET; i < NSTR; i++) s += int'(vals[i][c]);
`ifdef ADC_CAL_ROUND_EN
    s += 8;
`endif
    return 12'(s / 16);
  endfunction

  task automatic drive_v();
    bus.ad_a0 = v[0];
    bus.ad_a1 = v[1];
    bus.ad_b0 = v[2];
    bus.ad_b1 = v[3];
  endtask

  task automatic strobe_v();
    drive_v();
    bus.ad_strobe = 1'b1;
    tick();
    bus.ad_strobe = 1'b0;
  endtask

  task automatic pulse_req();
    cal_req = 1'b1;
    tick();
    cal_req = 1'b0;
  endtask

  task automatic chk_offs(input string tag);
    for (int c = 0; c < 4; c++)
      chk($sformatf("%s_off%0d", tag, c), off_of(c), m_off[c]);
  endtask

  task automatic chk_corr(input string tag);
    for (int c = 0; c < 4; c++)
      chk($sformatf("%s_corr%0d", tag, c), corr_of(c),
          sat(v[c], m_off[c]));
  endtask

  task automatic run_strobe(input string tag);
    strobe_v();
    chk($sformatf("%s_cs", tag), bus.corr_strobe, 1'b1);
    chk_corr(tag);
    tick();
    chk($sformatf("%s_cs_off", tag), bus.corr_strobe, 1'b0);
    chk_corr($sformatf("%s_hold", tag));
  endtask

  // Feeds vals[] at one strobe per 16 cycles; checks the outcome.
  task automatic run_cal(input string tag);
    bit ok = 1'b1;
    logic [11:0] a [4];
    for (int c = 0; c < 4; c++) begin
      a[c] = avg_of(c);
      if (a[c] > 12'h040) ok = 1'b0;
    end
    for (int i = 0; i < NSTR; i++) begin
      for (int c = 0; c < 4; c++) v[c] = vals[i][c];
      strobe_v();
      chk($sformatf("%s_nocs%0d", tag, i), bus.corr_strobe, 1'b0);
      if (i < NSTR - 1) idle(15);
    end
    chk({tag, "_done_early"}, cal_done, 1'b0);
    chk({tag, "_busy_chk"}, cal_busy, 1'b1);
    tick();
    if (ok) begin
      for (int c = 0; c < 4; c++) m_off[c] = a[c];
      chk({tag, "_done"}, cal_done, 1'b1);
      chk({tag, "_err"}, cal_err, 1'b0);
      chk({tag, "_busy"}, cal_busy, 1'b0);
      chk({tag, "_en"}, bus.adc_en, 1'b1);
    end else begin
      chk({tag, "_done"}, cal_done, 1'b0);
      chk({tag, "_err"}, cal_err, 1'b1);
      chk({tag, "_busy"}, cal_busy, 1'b0);
      chk({tag, "_en"}, bus.adc_en, 1'b0);
    end
    chk_offs(tag);
    tick();
    chk({tag, "_done_pulse"}, cal_done, 1'b0);
  endtask

  initial begin
    int n;
    v = '{default: 12'h000};
    m_off = '{default: 12'h000};
    drive_v();
    bus.ad_strobe = 1'b0;

    // Reset state
    idle(2);
    chk("rst_en", bus.adc_en, 1'b0);
    chk("rst_busy", cal_busy, 1'b0);
    chk("rst_err", cal_err, 1'b0);
    chk("rst_cs", bus.corr_strobe, 1'b0);
    chk_offs("rst");
    reset = 1'b1;
    idle(2);

    // Directed calibration; settle samples are junk and must be dropped
    pulse_req();
    chk("cal1_busy", cal_busy, 1'b1);
    chk("cal1_en", bus.adc_en, 1'b1);
    for (int i = 0; i < NSTR; i++) begin
      if (i < NSET) begin
        for (int c = 0; c < 4; c++) vals[i][c] = 12'($urandom);
      end else begin
        vals[i][0] = 12'h010;
        vals[i][1] = 12'h012;
        vals[i][2] = 12'h008;
        vals[i][3] = 12'h020;
      end
    end
    run_cal("cal1");
    chk("cal1_a0", off_a0, 12'h010);
    chk("cal1_b1", off_b1, 12'h020);

    // Directed correction with saturation on b1
    v[0] = 12'h110;
    v[1] = 12'($urandom);
    v[2] = 12'($urandom);
    v[3] = 12'h005;
    run_strobe("corr_dir");
    chk("corr_a0_val", bus.corr_a0, 12'h100);
    chk("corr_b1_sat", bus.corr_b1, 12'h000);

    // Random correction
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++)
        v[c] = (k % 2 == 0) ? 12'($urandom_range(0, 'h60))
                            : 12'($urandom);
      run_strobe($sformatf("corr_r%0d", k));
      idle($urandom_range(0, 3));
    end

    // cal_req coinciding with a RUN strobe
    for (int c = 0; c < 4; c++) v[c] = 12'($urandom);
    drive_v();
    bus.ad_strobe = 1'b1;
    cal_req = 1'b1;
    tick();
    bus.ad_strobe = 1'b0;
    cal_req = 1'b0;
    chk("coinc_cs", bus.corr_strobe, 1'b1);
    chk_corr("coinc");
    chk("coinc_busy", cal_busy, 1'b1);
    for (int i = 0; i < NSTR; i++)
      for (int c = 0; c < 4; c++)
        vals[i][c] = 12'($urandom_range(0, 'h3f));
    run_cal("cal2");

    // Range error on b1
    pulse_req();
    for (int i = 0; i < NSTR; i++)
      for (int c = 0; c < 4; c++)
        vals[i][c] = (c == 3 && i >= NSET) ? 12'h100
                     : 12'($urandom_range(0, 'h3f));
    run_cal("rng");
    for (int c = 0; c < 4; c++) v[c] = 12'($urandom);
    strobe_v();
    chk("rng_idle_cs", bus.corr_strobe, 1'b0);

    // Strobe timeout in ACCUM
    pulse_req();
    chk("tmo_err_clr", cal_err, 1'b0);
    for (int i = 0; i < NSET + 5; i++) begin
      for (int c = 0; c < 4; c++) v[c] = 12'($urandom_range(0, 'h3f));
      strobe_v();
      if (i < NSET + 4) idle(3);
    end
    n = 0;
    while (!cal_err && n < 200) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, 64);
    chk("tmo_en", bus.adc_en, 1'b0);
    chk("tmo_busy", cal_busy, 1'b0);
    chk_offs("tmo");
    pulse_req();
    chk("tmo_req_clr", cal_err, 1'b0);

    // Reset mid-ACCUM
    for (int i = 0; i < NSET + 3; i++) begin
      for (int c = 0; c < 4; c++) v[c] = 12'($urandom);
      strobe_v();
      idle(3);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_off = '{default: 12'h000};
    chk("mid_en", bus.adc_en, 1'b0);
    chk("mid_busy", cal_busy, 1'b0);
    chk("mid_err", cal_err, 1'b0);
    chk("mid_done", cal_done, 1'b0);
    chk("mid_cs", bus.corr_strobe, 1'b0);
    chk_offs("mid");
    for (int c = 0; c < 4; c++)
      chk($sformatf("mid_corr%0d", c), corr_of(c), 12'h000);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) v[c] = 12'($urandom);
      strobe_v();
      chk($sformatf("mid_nocs%0d", k), bus.corr_strobe, 1'b0);
      idle(2);
    end

    // Rounding: a0 alternates 0x010/0x011, sum 0x108
    pulse_req();
    for (int i = 0; i < NSTR; i++)
      for (int c = 0; c < 4; c++)
        vals[i][c] = 12'($urandom_range(0, 'h3f));
    for (int i = NSET; i < NSTR; i++)
      vals[i][0] = (i % 2 == 0) ? 12'h010 : 12'h011;
    run_cal("rnd");
`ifdef ADC_CAL_ROUND_EN
    chk("rnd_a0", off_a0, 12'h011);
`else
    chk("rnd_a0", off_a0, 12'h010);
`endif
    for (int c = 0; c < 4; c++) v[c] = 12'($urandom);
    run_strobe("rnd_corr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
